prism_in_filter: RTL

Per-channel input conditioner sitting directly upstream of the PRISM peripheral's `prism_in_data` bus. It takes the already-synchronised `ui_in` pins and applies a per-channel polarity invert and a programmable glitch filter. It then produces registered filtered levels, single-cycle rise/fall pulses and sticky edge flags with an interrupt request. The PRISM FSM and the 8-bit comm shifter consume `filt_o` instead of raw pins, so contact bounce and single-cycle glitches never reach FSM conditions.

---
 rtl/prism_in_filter.sv | 83 ++++++++
 1 files changed

// File: rtl/prism_in_filter.sv
// Per-channel input conditioner: polarity invert, programmable glitch filter,
// registered rise/fall pulses, sticky edge flags and a registered interrupt.
module prism_in_filter #(
    parameter int CHANNELS = 8,
    parameter int FILT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHANNELS-1:0]     raw_i,
    input  logic [CHANNELS-1:0]     inv_i,
    input  logic [CHANNELS-1:0]     filt_en_i,
    input  logic [FILT_W-1:0]       filt_len_i,
    input  logic [2*CHANNELS-1:0]   edge_sel_i,
    input  logic [CHANNELS-1:0]     flag_clr_i,
    input  logic [CHANNELS-1:0]     irq_en_i,
    output logic [CHANNELS-1:0]     filt_o,
    output logic [CHANNELS-1:0]     rise_o,
    output logic [CHANNELS-1:0]     fall_o,
    output logic [CHANNELS-1:0]     flag_o,
    output logic                    irq_o
);

    logic [CHANNELS-1:0] r_filt, r_rise, r_fall, r_flag;
    logic                r_irq;
    logic [FILT_W-1:0]   r_cnt [CHANNELS];

    logic [CHANNELS-1:0] w_s, w_filt_d, w_rise_d, w_fall_d, w_flag_d;
    logic                w_irq_d;
    logic [FILT_W-1:0]   w_cnt_d [CHANNELS];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        w_s      = raw_i ^ inv_i;
        w_filt_d = r_filt;
        w_rise_d = '0;
        w_fall_d = '0;
        w_flag_d = '0;
        w_irq_d  = |(r_flag & irq_en_i);
        for (int c = 0; c < CHANNELS; c++) begin
            w_cnt_d[c] = '0;
            // The >= lets a lowered length commit a channel that is already mid-count.
            if (w_s[c] != r_filt[c]) begin
                if (!filt_en_i[c] || (r_cnt[c] >= filt_len_i)) begin
                    w_filt_d[c] = w_s[c];
                    w_rise_d[c] = w_s[c];
                    w_fall_d[c] = ~w_s[c];
                end else begin
                    w_cnt_d[c] = r_cnt[c] + 1'b1;
                end
            end
            w_flag_d[c] = (r_rise[c] & edge_sel_i[2*c])
                        | (r_fall[c] & edge_sel_i[2*c+1])
                        | (r_flag[c] & ~flag_clr_i[c]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_filt <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_flag <= '0;
            r_irq  <= 1'b0;
            // NOTE: the counter array is reset too; a stale partial count would otherwise leak across reset.
            for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
        end else begin
            r_filt <= w_filt_d;
            r_rise <= w_rise_d;
            r_fall <= w_fall_d;
            r_flag <= w_flag_d;
            r_irq  <= w_irq_d;
            for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= w_cnt_d[c];
        end
    end

    assign filt_o = r_filt;
    assign rise_o = r_rise;
    assign fall_o = r_fall;
    assign flag_o = r_flag;
    assign irq_o  = r_irq;

endmodule
